// File: rtl/gsu_pkg.sv
// Shared GSU cache definitions: fill FSM encodings, cache geometry and the
// cache-index resolve used by both the fill path and the cache read path.
package gsu_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int CACHE_BYTES = 512;

    typedef enum logic [4:0] {
        ST_IDLE  = 5'b00001,
        ST_REQ   = 5'b00010,
        ST_WAIT  = 5'b00100,
        ST_WRITE = 5'b01000,
        ST_DONE  = 5'b10000
    } fill_state_t;

    // Program-space offset plus cache base, folded into the cache RAM.
    function automatic logic [8:0] cache_index(input logic [9:0] offset,
                                               input logic [9:0] cbr_lo,
                                               input int         cache_bytes);
        logic [10:0] sum;
        sum = {1'b0, offset} + {1'b0, cbr_lo};
        return 9'(int'(sum) % cache_bytes);
    endfunction

endpackage

// File: rtl/gsu_cache_fill.sv
// GSU instruction cache line fill: fetches one line from ROM byte by byte and
// writes it into the cache RAM, sharing the write port with the SNES CPU.
module gsu_cache_fill #(
    parameter int LINE_BYTES  = gsu_pkg::LINE_BYTES,
    parameter int CACHE_BYTES = gsu_pkg::CACHE_BYTES
) (
    input  logic        clkin,
    input  logic        RST,
    input  logic        miss_req,
    input  logic [15:0] miss_pc,
    input  logic [7:0]  pbr,
    input  logic [15:0] cbr,
    input  logic        ron,
    input  logic        flush,
    output logic        rom_req,
    output logic [23:0] rom_addr,
    input  logic        rom_ack,
    input  logic [7:0]  rom_data,
    input  logic        snes_we,
    input  logic [8:0]  snes_addr,
    input  logic [7:0]  snes_data,
    output logic        cache_we,
    output logic [8:0]  cache_waddr,
    output logic [7:0]  cache_wdata,
    output logic        flag_set,
    output logic        flag_clr_all,
    output logic [4:0]  flag_idx,
    output logic        busy,
    output logic        line_done
);

    gsu_pkg::fill_state_t state, state_nxt;

    logic [3:0]  cnt;
    logic [15:0] base;
    logic [7:0]  pbr_q;
    logic [7:0]  data_q;
    logic [23:0] rom_addr_q;
    logic [4:0]  last_idx;
    logic        pend_flag;
    logic [4:0]  pend_idx;

    logic       start_fill;
    logic       last_byte;
    logic       snes_flag;
    logic       fill_wr;
    logic       done_flag;
    logic [8:0] fill_waddr;
    logic       unused_bits;

    assign unused_bits = ^{cbr[15:10], miss_pc[3:0]};

    assign start_fill = (state == gsu_pkg::ST_IDLE) && miss_req && !flush;
    assign last_byte  = (cnt == 4'(LINE_BYTES - 1));
    assign snes_flag  = snes_we && (snes_addr[3:0] == 4'(LINE_BYTES - 1));
    assign fill_wr    = (state == gsu_pkg::ST_WRITE) && !flush && !snes_we;
    assign done_flag  = (state == gsu_pkg::ST_DONE) && !flush;
    assign fill_waddr = gsu_pkg::cache_index(base[9:0] + {6'd0, cnt}, cbr[9:0], CACHE_BYTES);

    always_ff @(posedge clkin or posedge RST) begin
        if (RST) begin
            state <= gsu_pkg::ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A SNES write holds a pending fill write in WRITE; flush aborts from anywhere.
    always_comb begin
        state_nxt = state;
        case (state)
            gsu_pkg::ST_IDLE: begin
                if (miss_req && !flush) state_nxt = gsu_pkg::ST_REQ;
            end
            gsu_pkg::ST_REQ: begin
                if (flush)    state_nxt = gsu_pkg::ST_IDLE;
                else if (ron) state_nxt = gsu_pkg::ST_WAIT;
            end
            gsu_pkg::ST_WAIT: begin
                if (flush)        state_nxt = gsu_pkg::ST_IDLE;
                else if (rom_ack) state_nxt = gsu_pkg::ST_WRITE;
            end
            gsu_pkg::ST_WRITE: begin
                if (flush)         state_nxt = gsu_pkg::ST_IDLE;
                else if (!snes_we) state_nxt = last_byte ? gsu_pkg::ST_DONE : gsu_pkg::ST_REQ;
            end
            gsu_pkg::ST_DONE: begin
                state_nxt = gsu_pkg::ST_IDLE;
            end
            default: begin
                state_nxt = gsu_pkg::ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkin or posedge RST) begin
        if (RST) begin
            cnt        <= 4'd0;
            base       <= 16'd0;
            pbr_q      <= 8'd0;
            data_q     <= 8'd0;
            rom_addr_q <= 24'd0;
            last_idx   <= 5'd0;
            pend_flag  <= 1'b0;
            pend_idx   <= 5'd0;
        end else begin
            if (start_fill) begin
                base  <= {miss_pc[15:4], 4'h0};
                pbr_q <= pbr;
                cnt   <= 4'd0;
            end
            if ((state == gsu_pkg::ST_REQ) && ron && !flush) begin
                rom_addr_q <= {pbr_q, base + {12'd0, cnt}};
            end
            if ((state == gsu_pkg::ST_WAIT) && rom_ack && !flush) begin
                data_q <= rom_data;
            end
            if (fill_wr) begin
                last_idx <= fill_waddr[8:4];
                if (!last_byte) cnt <= cnt + 4'd1;
            end
            // The line's flag waits while a SNES flag owns the flag port.
            pend_flag <= (done_flag || pend_flag) && snes_flag && !flush;
            if (done_flag && snes_flag) begin
                pend_idx <= last_idx;
            end
        end
    end

    always_comb begin
        rom_req      = (state == gsu_pkg::ST_WAIT);
        rom_addr     = rom_addr_q;
        busy         = (state != gsu_pkg::ST_IDLE);
        line_done    = done_flag;
        flag_clr_all = flush;

        cache_we    = 1'b0;
        cache_waddr = 9'd0;
        cache_wdata = 8'd0;
        if (snes_we) begin
            cache_we    = 1'b1;
            cache_waddr = snes_addr;
            cache_wdata = snes_data;
        end else if ((state == gsu_pkg::ST_WRITE) && !flush) begin
            cache_we    = 1'b1;
            cache_waddr = fill_waddr;
            cache_wdata = data_q;
        end

        flag_set = 1'b0;
        flag_idx = 5'd0;
        if (snes_flag) begin
            flag_set = 1'b1;
            flag_idx = snes_addr[8:4];
        end else if (done_flag) begin
            flag_set = 1'b1;
            flag_idx = last_idx;
        end else if (pend_flag && !flush) begin
            flag_set = 1'b1;
            flag_idx = pend_idx;
        end
    end

endmodule

// File: tb/tb_gsu_cache_fill.sv
// Directed and randomized line fills against a line-level model of the
// expected ROM reads, cache writes, flag events and fill latency.
module tb_gsu_cache_fill;

    logic        clkin;
    logic        RST;
    logic        miss_req;
    logic [15:0] miss_pc;
    logic [7:0]  pbr;
    logic [15:0] cbr;
    logic        ron;
    logic        flush;
    logic        rom_req;
    logic [23:0] rom_addr;
    logic        rom_ack;
    logic [7:0]  rom_data;
    logic        snes_we;
    logic [8:0]  snes_addr;
    logic [7:0]  snes_data;
    logic        cache_we;
    logic [8:0]  cache_waddr;
    logic [7:0]  cache_wdata;
    logic        flag_set;
    logic        flag_clr_all;
    logic [4:0]  flag_idx;
    logic        busy;
    logic        line_done;

    gsu_cache_fill dut (
        .clkin(clkin), .RST(RST), .miss_req(miss_req), .miss_pc(miss_pc), .pbr(pbr),
        .cbr(cbr), .ron(ron), .flush(flush), .rom_req(rom_req), .rom_addr(rom_addr),
        .rom_ack(rom_ack), .rom_data(rom_data), .snes_we(snes_we), .snes_addr(snes_addr),
        .snes_data(snes_data), .cache_we(cache_we), .cache_waddr(cache_waddr),
        .cache_wdata(cache_wdata), .flag_set(flag_set), .flag_clr_all(flag_clr_all),
        .flag_idx(flag_idx), .busy(busy), .line_done(line_done)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [16:0] wr_q[$];
    int          wr_cyc_q[$];
    logic [4:0]  fl_q[$];
    int          fl_cyc_q[$];
    logic [23:0] rom_q[$];

    int         rom_lat = 0;
    logic       stall_en = 1'b0;
    logic [3:0] stall_nib = 4'd0;
    int         late_req = 0;
    int         late_done = 0;
    int         wait_cnt = 0;

    initial begin
        clkin = 1'b0;
        forever #5 clkin = ~clkin;
    end

    initial forever begin
        @(posedge clkin);
        cyc++;
    end

    function automatic logic [7:0] rom_byte(input logic [23:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ a[23:16] ^ 8'h5A;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ROM: acks rom_lat cycles after the request is seen, or stalls on one byte.
    initial begin
        rom_ack  = 1'b0;
        rom_data = 8'd0;
        forever begin
            @(negedge clkin);
            rom_ack = 1'b0;
            if (late_req != late_done) begin
                late_done = late_req;
                rom_ack   = 1'b1;
                rom_data  = 8'hEE;
            end else if (rom_req && !(stall_en && rom_addr[3:0] == stall_nib)) begin
                if (wait_cnt >= rom_lat) begin
                    rom_ack  = 1'b1;
                    rom_data = rom_byte(rom_addr);
                    rom_q.push_back(rom_addr);
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial forever begin
        @(negedge clkin);
        #1;
        if (cache_we === 1'b1) begin
            wr_q.push_back({cache_waddr, cache_wdata});
            wr_cyc_q.push_back(cyc);
        end
        if (flag_set === 1'b1) begin
            fl_q.push_back(flag_idx);
            fl_cyc_q.push_back(cyc);
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_rom_req"}, 32'(rom_req), 32'd0);
        chk({tag, "_rom_addr"}, 32'(rom_addr), 32'd0);
        chk({tag, "_cache_we"}, 32'(cache_we), 32'd0);
        chk({tag, "_cache_waddr"}, 32'(cache_waddr), 32'd0);
        chk({tag, "_cache_wdata"}, 32'(cache_wdata), 32'd0);
        chk({tag, "_flag_set"}, 32'(flag_set), 32'd0);
        chk({tag, "_flag_clr_all"}, 32'(flag_clr_all), 32'd0);
        chk({tag, "_flag_idx"}, 32'(flag_idx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_line_done"}, 32'(line_done), 32'd0);
    endtask

    // snes_j: -1 none, 0..15 collides with that fill byte's write, 16 lands in DONE.
    task automatic run_fill(input string tag, input logic [15:0] pc, input logic [7:0] bank,
                            input logic [15:0] cb, input int hold, input int lat,
                            input int snes_j, input logic [8:0] s_addr, input logic [7:0] s_data,
                            input bit pre_armed);
        int wr0, rm0, fl0, done_k, snes_cyc, exp_lat, idx;
        logic hold_ok;
        logic [15:0] base;
        logic [23:0] ra;
        logic [8:0]  wa;
        logic [16:0] exp_wr_q[$];
        logic [4:0]  exp_fl_q[$];
        logic [23:0] exp_rom_q[$];

        wr0 = wr_q.size();
        rm0 = rom_q.size();
        fl0 = fl_q.size();
        rom_lat = lat;
        cbr = cb;
        done_k = 0;
        hold_ok = 1'b1;
        if (snes_j < 0)        snes_cyc = -1;
        else if (snes_j == 16) snes_cyc = 49 + hold + 16 * lat;
        else                   snes_cyc = hold + snes_j * (3 + lat) + 3 + lat;

        if (!pre_armed) begin
            @(posedge clkin); #1;
            miss_pc = pc;
            pbr = bank;
            miss_req = 1'b1;
        end
        @(posedge clkin); #1;
        miss_req = 1'b0;
        miss_pc = 16'($urandom);
        pbr = 8'($urandom);
        for (int k = 1; k <= 600; k++) begin
            if (k > 1) begin
                @(posedge clkin); #1;
            end
            ron = (k > hold);
            snes_we = (k == snes_cyc);
            snes_addr = s_addr;
            snes_data = s_data;
            @(negedge clkin);
            if (k <= hold && (busy !== 1'b1 || rom_req !== 1'b0)) hold_ok = 1'b0;
            if (line_done === 1'b1) begin
                done_k = k;
                break;
            end
        end
        @(posedge clkin); #1;
        snes_we = 1'b0;
        ron = 1'b1;
        repeat (3) @(posedge clkin);
        #1;

        base = {pc[15:4], 4'h0};
        wa = 9'd0;
        for (int i = 0; i < 16; i++) begin
            if (i == snes_j) exp_wr_q.push_back({s_addr, s_data});
            ra = {bank, base + 16'(i)};
            exp_rom_q.push_back(ra);
            wa = 9'((int'(base[9:0]) + i + int'(cb[9:0])) % 512);
            exp_wr_q.push_back({wa, rom_byte(ra)});
        end
        if (snes_j == 16) exp_wr_q.push_back({s_addr, s_data});
        if (snes_j >= 0 && s_addr[3:0] == 4'hF) exp_fl_q.push_back(s_addr[8:4]);
        exp_fl_q.push_back(wa[8:4]);
        exp_lat = 49 + hold + 16 * lat + ((snes_j >= 0 && snes_j < 16) ? 1 : 0);

        chk({tag, "_latency"}, 32'(done_k), 32'(exp_lat));
        if (hold > 0) chk({tag, "_ron_hold"}, 32'(hold_ok), 32'd1);
        chk({tag, "_rom_count"}, 32'(rom_q.size() - rm0), 32'(exp_rom_q.size()));
        for (int i = 0; i < exp_rom_q.size(); i++) begin
            idx = rm0 + i;
            chk({tag, "_rom_addr"}, 32'((idx < rom_q.size()) ? rom_q[idx] : 24'hFFFFFF), 32'(exp_rom_q[i]));
        end
        chk({tag, "_wr_count"}, 32'(wr_q.size() - wr0), 32'(exp_wr_q.size()));
        for (int i = 0; i < exp_wr_q.size(); i++) begin
            idx = wr0 + i;
            chk({tag, "_cache_wr"}, 32'((idx < wr_q.size()) ? wr_q[idx] : 17'h1FFFF), 32'(exp_wr_q[i]));
        end
        chk({tag, "_flag_count"}, 32'(fl_q.size() - fl0), 32'(exp_fl_q.size()));
        for (int i = 0; i < exp_fl_q.size(); i++) begin
            idx = fl0 + i;
            chk({tag, "_flag_idx"}, 32'((idx < fl_q.size()) ? fl_q[idx] : 5'h1F), 32'(exp_fl_q[i]));
        end
        if (snes_j >= 0 && snes_j < 16 && wr_cyc_q.size() > wr0 + snes_j + 1) begin
            chk({tag, "_fill_after_snes"},
                32'(wr_cyc_q[wr0 + snes_j + 1] - wr_cyc_q[wr0 + snes_j]), 32'd1);
        end
        if (snes_j == 16 && fl_cyc_q.size() >= fl0 + 2) begin
            chk({tag, "_fill_flag_delay"},
                32'(fl_cyc_q[fl0 + 1] - fl_cyc_q[fl0]), 32'd1);
        end
    endtask

    initial begin
        int found, wr0, fl0, rm0, sj;
        logic [8:0] sa;

        RST = 1'b1;
        miss_req = 1'b0;
        miss_pc = 16'hBEEF;
        pbr = 8'h7E;
        cbr = 16'h03FF;
        ron = 1'b1;
        flush = 1'b0;
        snes_we = 1'b0;
        snes_addr = 9'd0;
        snes_data = 8'd0;
        #2;
        check_all_zero("reset");
        repeat (2) @(posedge clkin);
        #1;
        RST = 1'b0;

        run_fill("basic", 16'h0123, 8'h01, 16'h0000, 0, 0, -1, 9'd0, 8'd0, 1'b0);
        chk("basic_flag_const", 32'(fl_q[fl_q.size() - 1]), 32'h12);
        chk("basic_first_rom", 32'(rom_q[rom_q.size() - 16]), 32'h010120);
        chk("basic_last_waddr", 32'(wr_q[wr_q.size() - 1][16:8]), 32'h12F);

        run_fill("wrap", 16'h0020, 8'h05, 16'h01F0, 0, 0, -1, 9'd0, 8'd0, 1'b0);
        chk("wrap_flag_const", 32'(fl_q[fl_q.size() - 1]), 32'h01);
        chk("wrap_first_waddr", 32'(wr_q[wr_q.size() - 16][16:8]), 32'h010);

        run_fill("contend", 16'h0340, 8'h02, 16'h0000, 0, 0, 5, 9'h0AB, 8'hC3, 1'b0);
        run_fill("ron_hold", 16'h1230, 8'h04, 16'h0000, 20, 0, -1, 9'd0, 8'd0, 1'b0);
        run_fill("snes_done", 16'h2200, 8'h06, 16'h0010, 0, 0, 16, 9'h07F, 8'h99, 1'b0);
        run_fill("slow_rom", 16'hFFF7, 8'hFF, 16'h0123, 2, 2, 15, 9'h1EF, 8'h3C, 1'b0);

        for (int r = 0; r < 8; r++) begin
            sj = int'($urandom_range(17, 0)) - 1;
            sa = 9'($urandom);
            if (sj == 16) sa[3:0] = 4'hF;
            run_fill("rand", 16'($urandom), 8'($urandom), 16'($urandom),
                     int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                     sj, sa, 8'($urandom), 1'b0);
        end

        // Abort while waiting on byte 7, then a stray ack after the flush.
        wr0 = wr_q.size();
        fl0 = fl_q.size();
        rm0 = rom_q.size();
        stall_nib = 4'd7;
        stall_en = 1'b1;
        rom_lat = 0;
        cbr = 16'h0000;
        found = 0;
        @(posedge clkin); #1;
        miss_pc = 16'h4560;
        pbr = 8'h02;
        miss_req = 1'b1;
        @(posedge clkin); #1;
        miss_req = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clkin);
            if (rom_req === 1'b1 && rom_addr[3:0] == 4'd7) begin
                found = 1;
                break;
            end
            @(posedge clkin); #1;
        end
        chk("abort_reach_byte7", 32'(found), 32'd1);
        @(posedge clkin); #1;
        flush = 1'b1;
        @(negedge clkin);
        chk("abort_clr_all", 32'(flag_clr_all), 32'd1);
        chk("abort_flag_set", 32'(flag_set), 32'd0);
        @(posedge clkin); #1;
        flush = 1'b0;
        late_req++;
        @(negedge clkin);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_rom_req", 32'(rom_req), 32'd0);
        repeat (6) @(posedge clkin);
        #1;
        chk("abort_busy_after_ack", 32'(busy), 32'd0);
        chk("abort_wr_count", 32'(wr_q.size() - wr0), 32'd7);
        chk("abort_flag_count", 32'(fl_q.size() - fl0), 32'd0);
        chk("abort_rom_count", 32'(rom_q.size() - rm0), 32'd7);
        stall_en = 1'b0;

        // Reset in the middle of a fill, miss held across the release.
        fl0 = fl_q.size();
        @(posedge clkin); #1;
        miss_pc = 16'h0AB0;
        pbr = 8'h03;
        cbr = 16'h0005;
        miss_req = 1'b1;
        repeat (10) @(posedge clkin);
        #1;
        RST = 1'b1;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(posedge clkin);
        #1;
        chk("mid_reset_no_flag", 32'(fl_q.size() - fl0), 32'd0);
        RST = 1'b0;
        run_fill("after_reset", 16'h0AB0, 8'h03, 16'h0005, 0, 0, -1, 9'd0, 8'd0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
